// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: tag/data/op widths, the reserved INVALID_TAG and the station entry state.
// INVALID_TAG on an operand means its value is already present.
package tomasulo_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 5;
    localparam int AGE_W  = 8;

    localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } rs_state_t;

    // A broadcast of INVALID_TAG never matches anything.
    function automatic logic tag_hit(input logic cdb_vld,
                                     input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] tag);
        return cdb_vld && (cdb_tag != INVALID_TAG) && (cdb_tag == tag);
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One station slot: captures an issued instruction, snoops the CDB for missing operands.
// Latency: state changes on the edge after alloc/CDB/issue; no combinational input-to-output paths.
// Backpressure: holds READY until issue; holds EXEC until the CDB carries its own tag.
module rs_entry
    import tomasulo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  own_tag,
    input  logic              alloc,
    input  logic [OP_W-1:0]   alloc_op,
    input  logic [DATA_W-1:0] alloc_val_1,
    input  logic [DATA_W-1:0] alloc_val_2,
    input  logic [TAG_W-1:0]  alloc_tag_1,
    input  logic [TAG_W-1:0]  alloc_tag_2,
    input  logic              cdb_vld,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_val,
    input  logic              issue,
`ifdef RS_OLDEST_FIRST_EN
    output logic [AGE_W-1:0]  age,
`endif
    output logic              is_free,
    output logic              is_ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] val_1,
    output logic [DATA_W-1:0] val_2
);

    rs_state_t         state;
    logic [TAG_W-1:0]  tag_1, tag_2;
    logic [TAG_W-1:0]  src_tag_1, src_tag_2, nxt_tag_1, nxt_tag_2;
    logic [DATA_W-1:0] src_val_1, src_val_2, nxt_val_1, nxt_val_2;
    logic              hit_1, hit_2, capture;

    // On allocation the incoming operands are snooped too, so a coinciding CDB result is not lost.
    always_comb begin
        src_tag_1 = alloc ? alloc_tag_1 : tag_1;
        src_tag_2 = alloc ? alloc_tag_2 : tag_2;
        src_val_1 = alloc ? alloc_val_1 : val_1;
        src_val_2 = alloc ? alloc_val_2 : val_2;
        hit_1     = tag_hit(cdb_vld, cdb_tag, src_tag_1);
        hit_2     = tag_hit(cdb_vld, cdb_tag, src_tag_2);
        nxt_tag_1 = hit_1 ? INVALID_TAG : src_tag_1;
        nxt_tag_2 = hit_2 ? INVALID_TAG : src_tag_2;
        nxt_val_1 = hit_1 ? cdb_val : src_val_1;
        nxt_val_2 = hit_2 ? cdb_val : src_val_2;
        capture   = alloc || (state == ST_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FREE;
            op    <= '0;
            tag_1 <= INVALID_TAG;
            tag_2 <= INVALID_TAG;
            val_1 <= '0;
            val_2 <= '0;
        end else begin
            if (alloc)
                op <= alloc_op;
            if (capture) begin
                tag_1 <= nxt_tag_1;
                tag_2 <= nxt_tag_2;
                val_1 <= nxt_val_1;
                val_2 <= nxt_val_2;
                state <= (nxt_tag_1 == INVALID_TAG && nxt_tag_2 == INVALID_TAG) ? ST_READY : ST_WAIT;
            end else if (state == ST_READY && issue) begin
                state <= ST_EXEC;
            end else if (state == ST_EXEC && tag_hit(cdb_vld, cdb_tag, own_tag)) begin
                state <= ST_FREE;
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // Cycles since allocation, saturating; saturated ties fall back to lowest index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            age <= '0;
        else if (alloc)
            age <= '0;
        else if (state != ST_FREE && age != {AGE_W{1'b1}})
            age <= age + {{(AGE_W-1){1'b0}}, 1'b1};
    end
`endif

    assign is_free  = (state == ST_FREE);
    assign is_ready = (state == ST_READY);

endmodule

// File: rtl/reservation_station.sv
// Reservation station: NUM_ENTRIES slots, lowest-FREE allocation, CDB snoop, one FU dispatch port.
// Latency: ack one cycle after allocation; FU offer is combinational from registered entry state.
// Backpressure: requests wait while full or acking; READY entries wait for in_fu_ready. Option: RS_OLDEST_FIRST_EN.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int               NUM_ENTRIES = 4,
    parameter logic [TAG_W-1:0] BASE_TAG    = 5'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_rs_req,
    input  logic [OP_W-1:0]   in_operator_type,
    input  logic [DATA_W-1:0] in_val_1,
    input  logic [DATA_W-1:0] in_val_2,
    input  logic [TAG_W-1:0]  in_tag_1,
    input  logic [TAG_W-1:0]  in_tag_2,
    output logic              out_rs_ack,
    output logic [TAG_W-1:0]  out_rs_tag,
    output logic              out_full,
    input  logic              in_CDB_broadcast,
    input  logic [TAG_W-1:0]  in_CDB_tag,
    input  logic [DATA_W-1:0] in_CDB_val,
    output logic              out_fu_valid,
    output logic [OP_W-1:0]   out_fu_op,
    output logic [DATA_W-1:0] out_fu_a,
    output logic [DATA_W-1:0] out_fu_b,
    output logic [TAG_W-1:0]  out_fu_tag,
    input  logic              in_fu_ready
);

    logic [NUM_ENTRIES-1:0] free_vec, ready_vec, alloc_vec, sel_vec, issue_vec;
    logic [TAG_W-1:0]       ent_tag [NUM_ENTRIES];
    logic [OP_W-1:0]        ent_op  [NUM_ENTRIES];
    logic [DATA_W-1:0]      ent_v1  [NUM_ENTRIES];
    logic [DATA_W-1:0]      ent_v2  [NUM_ENTRIES];
`ifdef RS_OLDEST_FIRST_EN
    logic [AGE_W-1:0]       ent_age [NUM_ENTRIES];
    logic [AGE_W-1:0]       sel_age;
`endif
    logic                   alloc_fire, alloc_found;
    logic [TAG_W-1:0]       alloc_tag;

    assign out_full   = ~|free_vec;
    assign alloc_fire = in_rs_req && !out_full && !out_rs_ack;

    always_comb begin
        alloc_vec   = '0;
        alloc_tag   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (free_vec[i] && !alloc_found) begin
                alloc_found  = 1'b1;
                alloc_vec[i] = alloc_fire;
                alloc_tag    = ent_tag[i];
            end
        end
    end

    always_comb begin
        sel_vec      = '0;
        out_fu_valid = 1'b0;
        out_fu_op    = '0;
        out_fu_a     = '0;
        out_fu_b     = '0;
        out_fu_tag   = '0;
`ifdef RS_OLDEST_FIRST_EN
        sel_age      = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ready_vec[i] && (!out_fu_valid || ent_age[i] > sel_age)) begin
                sel_age      = ent_age[i];
`else
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ready_vec[i] && !out_fu_valid) begin
`endif
                sel_vec      = '0;
                sel_vec[i]   = 1'b1;
                out_fu_valid = 1'b1;
                out_fu_op    = ent_op[i];
                out_fu_a     = ent_v1[i];
                out_fu_b     = ent_v2[i];
                out_fu_tag   = ent_tag[i];
            end
        end
    end

    assign issue_vec = sel_vec & {NUM_ENTRIES{in_fu_ready}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rs_ack <= 1'b0;
            out_rs_tag <= '0;
        end else begin
            out_rs_ack <= alloc_fire;
            out_rs_tag <= alloc_fire ? alloc_tag : '0;
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        assign ent_tag[g] = BASE_TAG + TAG_W'(g);

        rs_entry u_entry (
            .clk         (clk),
            .rst         (rst),
            .own_tag     (ent_tag[g]),
            .alloc       (alloc_vec[g]),
            .alloc_op    (in_operator_type),
            .alloc_val_1 (in_val_1),
            .alloc_val_2 (in_val_2),
            .alloc_tag_1 (in_tag_1),
            .alloc_tag_2 (in_tag_2),
            .cdb_vld     (in_CDB_broadcast),
            .cdb_tag     (in_CDB_tag),
            .cdb_val     (in_CDB_val),
            .issue       (issue_vec[g]),
`ifdef RS_OLDEST_FIRST_EN
            .age         (ent_age[g]),
`endif
            .is_free     (free_vec[g]),
            .is_ready    (ready_vec[g]),
            .op          (ent_op[g]),
            .val_1       (ent_v1[g]),
            .val_2       (ent_v2[g])
        );
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: allocation, CDB snoop/bypass, full, dispatch order, reset.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_rs_req;
    logic [4:0]  in_operator_type;
    logic [31:0] in_val_1, in_val_2;
    logic [4:0]  in_tag_1, in_tag_2;
    logic        out_rs_ack;
    logic [4:0]  out_rs_tag;
    logic        out_full;
    logic        in_CDB_broadcast;
    logic [4:0]  in_CDB_tag;
    logic [31:0] in_CDB_val;
    logic        out_fu_valid;
    logic [4:0]  out_fu_op;
    logic [31:0] out_fu_a, out_fu_b;
    logic [4:0]  out_fu_tag;
    logic        in_fu_ready;

    int total = 0;
    int bad   = 0;

    logic [4:0]  first_tag, second_tag;
    logic [31:0] first_a;

    reservation_station dut (
        .clk              (clk),
        .rst              (rst),
        .in_rs_req        (in_rs_req),
        .in_operator_type (in_operator_type),
        .in_val_1         (in_val_1),
        .in_val_2         (in_val_2),
        .in_tag_1         (in_tag_1),
        .in_tag_2         (in_tag_2),
        .out_rs_ack       (out_rs_ack),
        .out_rs_tag       (out_rs_tag),
        .out_full         (out_full),
        .in_CDB_broadcast (in_CDB_broadcast),
        .in_CDB_tag       (in_CDB_tag),
        .in_CDB_val       (in_CDB_val),
        .out_fu_valid     (out_fu_valid),
        .out_fu_op        (out_fu_op),
        .out_fu_a         (out_fu_a),
        .out_fu_b         (out_fu_b),
        .out_fu_tag       (out_fu_tag),
        .in_fu_ready      (in_fu_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [4:0] t1, input logic [4:0] t2,
                         input logic [31:0] v1, input logic [31:0] v2);
        in_rs_req        = 1'b1;
        in_operator_type = op;
        in_tag_1         = t1;
        in_tag_2         = t2;
        in_val_1         = v1;
        in_val_2         = v2;
    endtask

    task automatic cdb(input logic vld, input logic [4:0] t, input logic [31:0] v);
        in_CDB_broadcast = vld;
        in_CDB_tag       = t;
        in_CDB_val       = v;
    endtask

    initial begin
        rst = 1'b0;
        in_rs_req = 1'b0; in_operator_type = '0;
        in_val_1 = '0; in_val_2 = '0; in_tag_1 = 5'd31; in_tag_2 = 5'd31;
        cdb(1'b0, 5'd31, 32'h0);
        in_fu_ready = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_ack", out_rs_ack, 0);
        chk("rst_full", out_full, 0);
        chk("rst_fu_valid", out_fu_valid, 0);
        chk("rst_rs_tag", out_rs_tag, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_full", out_full, 0);
        chk("idle_fu_valid", out_fu_valid, 0);

        // Ready-at-issue instruction goes straight to the FU offer
        issue(5'd3, 5'd31, 5'd31, 32'd5, 32'd7);
        tick();
        chk("t1_ack", out_rs_ack, 1);
        chk("t1_tag", out_rs_tag, 0);
        chk("t1_fu_valid", out_fu_valid, 1);
        chk("t1_fu_op", out_fu_op, 3);
        chk("t1_fu_a", out_fu_a, 5);
        chk("t1_fu_b", out_fu_b, 7);
        chk("t1_fu_tag", out_fu_tag, 0);
        in_rs_req = 1'b0;
        in_fu_ready = 1'b1;
        tick();
        in_fu_ready = 1'b0;
        chk("t1_ack_drop", out_rs_ack, 0);
        chk("t1_dispatched", out_fu_valid, 0);

        // Operand 1 waits on tag 2, delivered by CDB two cycles later
        issue(5'd1, 5'd2, 5'd31, 32'hDEAD, 32'h11);
        tick();
        in_rs_req = 1'b0;
        chk("t2_ack", out_rs_ack, 1);
        chk("t2_tag", out_rs_tag, 1);
        chk("t2_wait", out_fu_valid, 0);
        tick();
        cdb(1'b1, 5'd2, 32'hAA);
        tick();
        cdb(1'b0, 5'd31, 32'h0);
        chk("t2_fu_valid", out_fu_valid, 1);
        chk("t2_fu_a", out_fu_a, 32'hAA);
        chk("t2_fu_b", out_fu_b, 32'h11);
        chk("t2_fu_tag", out_fu_tag, 1);
        in_fu_ready = 1'b1;
        tick();
        in_fu_ready = 1'b0;

        // CDB bypass on the allocation edge
        issue(5'd2, 5'd31, 5'd4, 32'h33, 32'h0);
        cdb(1'b1, 5'd4, 32'h55);
        tick();
        in_rs_req = 1'b0;
        cdb(1'b0, 5'd31, 32'h0);
        chk("t3_ack_tag", out_rs_tag, 2);
        chk("t3_fu_valid", out_fu_valid, 1);
        chk("t3_fu_a", out_fu_a, 32'h33);
        chk("t3_fu_b", out_fu_b, 32'h55);
        chk("t3_fu_tag", out_fu_tag, 2);
        tick();

        // Fill, refused request, then a freed EXEC entry is reused
        issue(5'd2, 5'd5, 5'd31, 32'h0, 32'h0);
        tick();
        chk("t4_ack", out_rs_ack, 1);
        chk("t4_tag", out_rs_tag, 3);
        chk("t4_full", out_full, 1);
        tick();
        tick();
        chk("t4_fifth_unacked", out_rs_ack, 0);
        chk("t4_still_full", out_full, 1);
        cdb(1'b1, 5'd1, 32'h0);
        tick();
        cdb(1'b0, 5'd31, 32'h0);
        chk("t4_freed_noack", out_rs_ack, 0);
        chk("t4_not_full", out_full, 0);
        tick();
        in_rs_req = 1'b0;
        chk("t4_reuse_ack", out_rs_ack, 1);
        chk("t4_reuse_tag", out_rs_tag, 1);
        chk("t4_full_again", out_full, 1);
        tick();

        // Entry 2 READY first, entry 0 READY later: dispatch order depends on policy
        cdb(1'b1, 5'd0, 32'h0);
        tick();
        cdb(1'b0, 5'd31, 32'h0);
        chk("t5_free0", out_full, 0);
        issue(5'd7, 5'd31, 5'd31, 32'h100, 32'h200);
        tick();
        in_rs_req = 1'b0;
        chk("t5_ack_tag", out_rs_tag, 0);
`ifdef RS_OLDEST_FIRST_EN
        first_tag = 5'd2; second_tag = 5'd0; first_a = 32'h33;
`else
        first_tag = 5'd0; second_tag = 5'd2; first_a = 32'h100;
`endif
        chk("t5_first_tag", out_fu_tag, first_tag);
        chk("t5_first_a", out_fu_a, first_a);
        in_fu_ready = 1'b1;
        tick();
        chk("t5_second_valid", out_fu_valid, 1);
        chk("t5_second_tag", out_fu_tag, second_tag);
        tick();
        in_fu_ready = 1'b0;
        chk("t5_none_left", out_fu_valid, 0);

        // Reset with WAIT entries and an ack pending
        cdb(1'b1, 5'd0, 32'h0);
        tick();
        cdb(1'b0, 5'd31, 32'h0);
        issue(5'd6, 5'd9, 5'd31, 32'h0, 32'h0);
        tick();
        in_rs_req = 1'b0;
        chk("t6_pending_ack", out_rs_ack, 1);
        chk("t6_full_before", out_full, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ack", out_rs_ack, 0);
        chk("t6_rst_full", out_full, 0);
        chk("t6_rst_fu_valid", out_fu_valid, 0);
        chk("t6_rst_rs_tag", out_rs_tag, 0);
        chk("t6_rst_fu_a", out_fu_a, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_full", out_full, 0);
        chk("t6_post_ack", out_rs_ack, 0);
        tick();
        chk("t6_post_ack2", out_rs_ack, 0);
        chk("t6_post_fu_valid", out_fu_valid, 0);

        // CDB tag INVALID_TAG must not overwrite a present operand
        issue(5'd4, 5'd5, 5'd31, 32'h0, 32'h77);
        tick();
        in_rs_req = 1'b0;
        chk("t7_ack", out_rs_ack, 1);
        cdb(1'b1, 5'd31, 32'hDEAD);
        tick();
        chk("t7_still_wait", out_fu_valid, 0);
        cdb(1'b1, 5'd5, 32'h66);
        tick();
        cdb(1'b0, 5'd31, 32'h0);
        chk("t7_fu_valid", out_fu_valid, 1);
        chk("t7_fu_a", out_fu_a, 32'h66);
        chk("t7_fu_b", out_fu_b, 32'h77);
        chk("t7_fu_op", out_fu_op, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, number of station entries (2..8).
REQ-002 Parameter BASE_TAG, default 5'd0; entry i owns tag BASE_TAG+i.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_rs_req  input  1  issue request from current-instruction stage, held until out_rs_ack.
REQ-006 in_operator_type  input  5  operation code of the issued instruction.
REQ-007 in_val_1, in_val_2  input  32 each  operand values, meaningful when matching tag is INVALID_TAG.
REQ-008 in_tag_1, in_tag_2  input  5 each  producer tags; INVALID_TAG means value present.
REQ-009 out_rs_ack  output  1  one-cycle acceptance pulse.
REQ-010 out_rs_tag  output  5  tag of the allocated entry, valid while out_rs_ack=1.
REQ-011 out_full  output  1  no FREE entry.
REQ-012 in_CDB_broadcast, in_CDB_tag, in_CDB_val  input  1/5/32  common data bus result.
REQ-013 out_fu_valid  output  1  a READY entry is offered to the functional unit.
REQ-014 out_fu_op, out_fu_a, out_fu_b, out_fu_tag  output  5/32/32/5  offered operation.
REQ-015 in_fu_ready  input  1  functional unit accepts this cycle.

Function
REQ-016 Each entry SHALL hold a state in {FREE, WAIT, READY, EXEC}, op, two values, two tags.
REQ-017 Allocation SHALL occur at an edge where in_rs_req=1, out_full=0, out_rs_ack=0; lowest-index FREE entry chosen.
REQ-018 out_rs_ack SHALL be 1 for exactly the cycle after allocation, with out_rs_tag = allocated tag; in_rs_req is ignored during that cycle.
REQ-019 Allocated entry SHALL enter READY if both captured tags are INVALID_TAG, else WAIT.
REQ-020 CDB snoop: when in_CDB_broadcast=1 and an entry tag in WAIT equals in_CDB_tag, value SHALL be captured and tag set to INVALID_TAG; entry moves to READY when both tags invalid.
REQ-021 CDB coinciding with allocation whose incoming tag matches SHALL be captured at that same edge (bypass).
REQ-022 in_CDB_tag = INVALID_TAG SHALL never match.
REQ-023 out_fu_valid and out_fu_* SHALL be combinational from registered entry state; selection per REQ-031.
REQ-024 Transfer at edge with out_fu_valid=1 and in_fu_ready=1; selected entry moves READY -> EXEC.
REQ-025 EXEC entry SHALL return to FREE when in_CDB_broadcast=1 and in_CDB_tag equals its own tag.
REQ-026 out_full SHALL be computed from registered state; an entry freed at edge k is allocatable from edge k+1.
REQ-027 Output widths exact; no arithmetic beyond tag = BASE_TAG+index (5-bit, no wrap permitted by parameter choice).

Reset
REQ-028 rst=1 SHALL immediately force all entries FREE, out_rs_ack=0, out_fu_valid=0, out_full=0, out_rs_tag=0, out_fu_*=0.
REQ-029 Reset mid-operation SHALL discard all entries; no ack or FU transfer SHALL follow without a new request.

Configuration
REQ-030 Macro RS_OLDEST_FIRST_EN selects FU dispatch policy.
REQ-031 Defined: oldest READY entry (per-entry allocation age counter) offered; undefined: lowest-index READY entry offered.

Structure
REQ-032 Shared package tomasulo_pkg SHALL hold INVALID_TAG=5'b11111, TAG_W=5, DATA_W=32, OP_W=5, entry-state enum.
REQ-033 One sub-module rs_entry (single-entry state, capture, CDB snoop) SHALL be instantiated NUM_ENTRIES times.

Verification
REQ-034 Issue op=3, tags 31/31, vals 5/7 -> ack next cycle, tag 0; out_fu_valid next cycle with a=5, b=7, tag 0.
REQ-035 Issue tag_1=2; CDB tag 2 val 0xAA two cycles later -> entry READY, out_fu_a=0xAA.
REQ-036 Issue tag_2=4 with CDB tag 4 val 0x55 on same edge -> captured, READY next cycle.
REQ-037 Fill 4 entries -> out_full=1, fifth request unacked; CDB own-tag on EXEC entry 1 -> next request gets tag 1.
REQ-038 Entries 2 then 0 become READY, in_fu_ready=1 -> with RS_OLDEST_FIRST_EN entry 2 first, without entry 0 first.
REQ-039 Assert rst with 3 WAIT entries and pending ack -> all outputs 0 immediately, out_full=0 after release.
